blocking_port_arbiter: RTL and testbench
========================================

# blocking_port_arbiter

Round-robin arbiter that shares one blocking sync/notify input port (integer payload, e.g. a `b_in`-style port of a generated module) between N producer ports. It accepts one message from the selected producer into a one-entry holding buffer, then forwards it to the shared consumer. It sits between several producer modules and a single consumer, so no producer ever drives the consumer port directly.

## Interface
Parameters:
- N, 4, number of producer ports (2..8)
- DW, 32, payload width (integer)

Ports:
- clk  input  1  clock; all state changes on posedge clk
- rst  input  1  reset, synchronous and active-high
- req_data  input  N×DW  producer payloads, slot i for producer i
- req_sync  input  N  producer i has a message; held high until notified
- req_notify  output  N  one-hot; producer i's message is taken this cycle
- out_data  output  DW  payload to consumer
- out_sync  output  1  out_data holds a valid message
- out_notify  input  1  consumer ready; transfer occurs when out_sync && out_notify at posedge

## Operation
- Handshake rule: a transfer on any port happens at a posedge where that port's sync and notify are both high. Data is sampled at that edge.
- State variable `section` has three states: idle, accept, send.
- idle:
  - If any req_sync is high, select g = first set bit, searching round-robin starting at last_grant+1 mod N.
  - Register g, set req_notify[g]=1, go to accept.
  - Otherwise stay in idle.
- accept (req_notify[g]=1, all other bits 0):
  - If req_sync[g]=1: capture req_data[g] into buf, clear req_notify, set out_sync=1, go to send.
  - If req_sync[g]=0 (producer withdrew): clear req_notify, go to idle. last_grant is unchanged.
- send (out_sync=1, out_data=buf):
  - If out_notify=1: clear out_sync, set last_grant=g, go to idle.
  - Otherwise hold indefinitely; out_data stays stable.
- New requests arriving during accept or send are ignored until the next idle evaluation.
- Reset (any state, including mid-transfer):
  - section=idle, req_notify=0, out_sync=0, out_data=0, buf=0.
  - last_grant=N-1, so producer 0 has first priority.
  - Any message in buf is discarded.
- No combinational path from any input to any output. All outputs are registered.

## Timing
- Request seen at edge k → req_notify[g] high in cycle k+1 → out_sync high in cycle k+2. Earliest consumer transfer is at edge k+2.
- Minimum 3 cycles per message. Back-to-back throughput is 1 message per 3 cycles with an always-ready consumer.
- req_notify is high for exactly one cycle per grant.
- Fairness: with all N producers continuously requesting, grants cycle 0,1,…,N-1,0. No producer waits more than N messages.
- Simultaneous rst and handshake: rst wins and no transfer is recorded.

## Configuration
- BLOCKING_PORT_ARB_STATS_EN
  - Defined: adds output xfer_count (32 bits), reset to 0. It increments on every completed consumer transfer and wraps from 2^32-1 to 0. It also adds output drop_count (16 bits), reset to 0, which increments on every withdrawal in accept and saturates at 16'hFFFF.
  - Undefined: neither port nor counter exists. Functional behaviour is otherwise identical.

## Structure
- Package blocking_port_arbiter_types holds:
  - typedef enum Sections {idle, accept, send}
  - constant ARB_MAX_N = 8
- Sub-module rr_priority_picker (combinational):
  - Inputs: req vector, last_grant.
  - Outputs: grant index and any_req.
  - Instantiated once; used only in idle.

## Test plan
- Single producer: reset; req_sync[2]=1, req_data[2]=42; consumer always ready → req_notify=4'b0100 for one cycle, out_data=42 with out_sync at cycle k+2, then idle.
- Round-robin: all four req_sync high with data 10,11,12,13, consumer always ready → out_data sequence 10,11,12,13,10. Transfers are 3 cycles apart.
- Backpressure: out_notify=0 for 5 cycles in send → out_sync and out_data hold. No req_notify is asserted to any producer. Transfer completes on the edge where out_notify=1.
- Withdrawal: producer 1 drops req_sync in its accept cycle → no out_sync, back to idle. last_grant stays at its previous value, so producer 1 is re-selected when it requests again. With stats enabled, drop_count=1.
- Reset mid-send: assert rst while out_sync=1 → next cycle out_sync=0, req_notify=0, out_data=0. The first post-reset grant goes to producer 0.
- Stats wrap (macro defined): force xfer_count to 32'hFFFF_FFFF, complete one transfer → xfer_count=0.

Source files
------------

// File: rtl/blocking_port_arbiter_pkg.sv
// Shared types for blocking_port_arbiter: FSM section encoding and the
// upper bound on the number of producer ports.
package blocking_port_arbiter_types;

    // Arbiter sections: idle picks a producer, accept takes its message,
    // send offers the buffered message to the consumer.
    typedef enum logic [1:0] {
        idle   = 2'd0,
        accept = 2'd1,
        send   = 2'd2
    } Sections;

    localparam int ARB_MAX_N = 8;

endpackage

// File: rtl/blocking_port_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search. Returns the first
// requesting index found starting at last_grant+1 (mod N), and whether any
// request is present at all.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [IW-1:0] grant_o,
    output logic          any_req_o
);

    // Walk the N positions after last_grant; the first hit wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        grant_o = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_grant_i) + k) % N;
            if (!found && req_i[idx]) begin
                grant_o = IW'(idx);
                found   = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/blocking_port_arbiter.sv
// blocking_port_arbiter: shares one blocking sync/notify consumer port
// between N producers through a one-entry holding buffer.
// Optional feature macro: BLOCKING_PORT_ARB_STATS_EN adds xfer_count and
// drop_count outputs.
//
// Handshake: on every port a transfer happens at a posedge where that
// port's sync and notify are both high; data is sampled at that edge.
// All outputs come straight from registers.
module blocking_port_arbiter
    import blocking_port_arbiter_types::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_sync,
    output logic [N-1:0]    req_notify,
    output logic [DW-1:0]   out_data,
    output logic            out_sync,
    input  logic            out_notify,
    output Sections         dbg_section
`ifdef BLOCKING_PORT_ARB_STATS_EN
    ,
    output logic [31:0]     xfer_count,
    output logic [15:0]     drop_count
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
        $error("blocking_port_arbiter: N must be in 2..ARB_MAX_N");
    end

    Sections         section_q;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   last_grant_q;
    logic [N-1:0]    req_notify_q;
    logic            out_sync_q;
    logic [DW-1:0]   buf_q;

    logic [IW-1:0]   pick;
    logic            any_req;

    rr_priority_picker #(.N(N), .IW(IW)) u_picker (
        .req_i        (req_sync),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    // Arbiter FSM: grant, accept into buffer, forward to consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            section_q    <= idle;
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
            req_notify_q <= '0;
            out_sync_q   <= 1'b0;
            buf_q        <= '0;
        end else begin
            case (section_q)
                idle: begin
                    if (any_req) begin
                        grant_q      <= pick;
                        req_notify_q <= {{(N-1){1'b0}}, 1'b1} << pick;
                        section_q    <= accept;
                    end
                end
                accept: begin
                    req_notify_q <= '0;
                    if (req_sync[grant_q]) begin
                        buf_q      <= req_data[int'(grant_q)*DW +: DW];
                        out_sync_q <= 1'b1;
                        section_q  <= send;
                    end else begin
                        // Producer withdrew; keep last_grant so it is not skipped.
                        section_q <= idle;
                    end
                end
                send: begin
                    if (out_notify) begin
                        out_sync_q   <= 1'b0;
                        last_grant_q <= grant_q;
                        section_q    <= idle;
                    end
                end
                default: begin
                    section_q    <= idle;
                    req_notify_q <= '0;
                    out_sync_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_notify  = req_notify_q;
    assign out_sync    = out_sync_q;
    assign out_data    = buf_q;
    assign dbg_section = section_q;

`ifdef BLOCKING_PORT_ARB_STATS_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Next counts: transfers wrap, withdrawals saturate.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (section_q == send && out_notify) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
        if (section_q == accept && !req_sync[grant_q] && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign xfer_count = xfer_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_blocking_port_arbiter.sv
// Testbench for blocking_port_arbiter: cycle table, round-robin sequence,
// randomized run against a reference model, optional stats checks.
module tb_blocking_port_arbiter;
    import blocking_port_arbiter_types::*;

    localparam int N  = 4;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_sync;
    logic [N-1:0]    req_notify;
    logic [DW-1:0]   out_data;
    logic            out_sync;
    logic            out_notify;
    Sections         dbg_section;
`ifdef BLOCKING_PORT_ARB_STATS_EN
    logic [31:0]     xfer_count;
    logic [15:0]     drop_count;
`endif

    always #5 clk = ~clk;

    blocking_port_arbiter #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_sync    (req_sync),
        .req_notify  (req_notify),
        .out_data    (out_data),
        .out_sync    (out_sync),
        .out_notify  (out_notify),
        .dbg_section (dbg_section)
`ifdef BLOCKING_PORT_ARB_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .drop_count  (drop_count)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_data(input logic [DW-1:0] d0, d1, d2, d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_sync = '0; out_notify = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic          rst;
        logic [N-1:0]  sync;
        logic          on;
        logic [N-1:0]  e_notify;
        logic          e_osync;
        logic [DW-1:0] e_odata;
    } vec_t;

    vec_t tbl[22];

    task automatic fill_table();
        // single producer 2 (data 42)
        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 32'd42};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'd42};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'd42};
        // producer 1, then 5 cycles of backpressure with others requesting
        tbl[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 32'd42};
        tbl[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[7]  = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[8]  = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[9]  = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[10] = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[11] = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd11};
        tbl[12] = '{1'b0, 4'b1101, 1'b1, 4'b0000, 1'b0, 32'd11};
        // next search starts at 2; producer 2 withdraws in accept
        tbl[13] = '{1'b0, 4'b1101, 1'b1, 4'b0100, 1'b0, 32'd11};
        tbl[14] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 1'b0, 32'd11};
        // last_grant unchanged -> producer 2 re-selected
        tbl[15] = '{1'b0, 4'b1101, 1'b1, 4'b0100, 1'b0, 32'd11};
        tbl[16] = '{1'b0, 4'b1101, 1'b0, 4'b0000, 1'b1, 32'd42};
        // reset mid-send, then producer 0 has first priority
        tbl[17] = '{1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 32'd0};
        tbl[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 32'd0};
        tbl[19] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'd10};
        tbl[20] = '{1'b0, 4'b1110, 1'b1, 4'b0000, 1'b0, 32'd10};
        tbl[21] = '{1'b0, 4'b1110, 1'b1, 4'b0010, 1'b0, 32'd10};
    endtask

    // ---------------- reference model (random phase) ----------------
    int            m_phase;   // 0 waiting for requests, 1 offered, 2 holding
    int            m_g;
    int            m_lg;
    logic [N-1:0]  m_notify;
    logic          m_osync;
    logic [DW-1:0] m_buf;
    int            m_xfer;
    int            m_drop;
    int            taken;
    logic [N-1:0]  pend;
    logic [DW-1:0] pdata[N];

    task automatic model_reset();
        m_phase = 0; m_g = 0; m_lg = N - 1;
        m_notify = '0; m_osync = 1'b0; m_buf = '0;
        m_xfer = 0; m_drop = 0; taken = -1;
        exp_q.delete();
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (req_sync != '0) begin
                        for (int k = 1; k <= N; k++) begin
                            if (req_sync[(m_lg + k) % N]) begin
                                m_g = (m_lg + k) % N;
                                break;
                            end
                        end
                        m_notify = '0;
                        m_notify[m_g] = 1'b1;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_notify = '0;
                    if (req_sync[m_g]) begin
                        m_buf   = pdata[m_g];
                        m_osync = 1'b1;
                        m_phase = 2;
                        exp_q.push_back(pdata[m_g]);
                        taken = m_g;
                    end else begin
                        m_phase = 0;
                        if (m_drop < 65535) m_drop++;
                    end
                end
                default: begin
                    if (out_notify) begin
                        m_osync = 1'b0;
                        m_lg    = m_g;
                        m_phase = 0;
                        m_xfer++;
                    end
                end
            endcase
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        int xfer_cyc[5];
        logic [DW-1:0] xfer_dat[5];
        logic [DW-1:0] rr_exp[5];

        rst = 1'b1; req_sync = '0; out_notify = 1'b1;
        set_data(32'd10, 32'd11, 32'd42, 32'd13);

        // table-driven phase
        fill_table();
        for (int r = 0; r < 22; r++) begin
            @(negedge clk);
            rst = tbl[r].rst; req_sync = tbl[r].sync; out_notify = tbl[r].on;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_notify", r), DW'(req_notify), DW'(tbl[r].e_notify));
            check($sformatf("tbl%0d_osync", r), DW'(out_sync), DW'(tbl[r].e_osync));
            check($sformatf("tbl%0d_odata", r), out_data, tbl[r].e_odata);
`ifdef BLOCKING_PORT_ARB_STATS_EN
            if (r == 12) check("stats_xfer2", xfer_count, 32'd2);
            if (r == 14) check("stats_drop1", DW'(drop_count), 32'd1);
`endif
        end

        // round-robin: all four requesting, consumer always ready
        set_data(32'd10, 32'd11, 32'd12, 32'd13);
        rr_exp = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
        apply_reset();
        req_sync = '1; out_notify = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_sync && seen < 5) begin
                xfer_cyc[seen] = c;
                xfer_dat[seen] = out_data;
                seen++;
            end
        end
        check("rr_count", DW'(seen), DW'(5));
        if (seen == 5) begin
            check("rr_first_latency", DW'(xfer_cyc[0]), DW'(2));
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rr_data%0d", i), xfer_dat[i], rr_exp[i]);
                if (i > 0) check($sformatf("rr_gap%0d", i), DW'(xfer_cyc[i] - xfer_cyc[i-1]), DW'(3));
            end
        end

        // randomized phase against the reference model
        @(negedge clk);
        rst = 1'b1; req_sync = '0; out_notify = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        model_reset();
        @(posedge clk);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            check("rnd_notify", DW'(req_notify), DW'(m_notify));
            check("rnd_osync", DW'(out_sync), DW'(m_osync));
            check("rnd_odata", out_data, m_buf);
            if (taken >= 0) pend[taken] = 1'b0;
            taken = -1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 30) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end else if (pend[i] && $urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end
            end
            rst        = ($urandom_range(0, 199) == 0);
            out_notify = ($urandom_range(0, 99) < 70);
            req_sync   = pend;
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
            if (!rst && out_sync && out_notify) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rnd_sb: got %0h expected nothing queued", out_data);
                end else begin
                    check("rnd_sb", out_data, exp_q.pop_front());
                end
            end
            model_step();
            @(posedge clk);
        end
`ifdef BLOCKING_PORT_ARB_STATS_EN
        @(negedge clk);
        check("rnd_xfer_count", xfer_count, DW'(m_xfer));
        check("rnd_drop_count", DW'(drop_count), DW'(m_drop));

        // wrap of the transfer counter
        apply_reset();
        set_data(32'd5, 32'd6, 32'd7, 32'd8);
        req_sync = 4'b0001; out_notify = 1'b1;
        force dut.xfer_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_cnt_q;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req_sync = '0;
        @(posedge clk);
        #1;
        check("stats_wrap", xfer_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
